// File: rtl/cache_pkg.sv
// Shared types and helpers for the cache refill controller.
// Holds the refill FSM state enum, default geometry and the address split.
package cache_pkg;

  localparam int LINE_WORDS_DEF = 4;
  localparam int INDEX_W_DEF    = 6;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
    TAG,
    FLUSH
  } refill_state_t;

  // Fields are right-aligned and zero-extended to the full word address.
  typedef struct packed {
    logic [29:0] tag;
    logic [29:0] index;
    logic [29:0] offset;
  } addr_split_t;

  function automatic addr_split_t split_addr(
    input logic [29:0] a,
    input int          idx_w,
    input int          off_w
  );
    addr_split_t s;
    s.offset = a & ((30'd1 << off_w) - 30'd1);
    s.index  = (a >> off_w) & ((30'd1 << idx_w) - 30'd1);
    s.tag    = a >> (off_w + idx_w);
    return s;
  endfunction

endpackage

// File: rtl/cache_refill_ctrl.sv
// Refill and flush sequencer for the direct-mapped cache.
// Ports: miss/flush level requests in, AHB-out ctrl (sel/addr/rdata/ready),
// data RAM write port, tag RAM write port, busy/done/critical-word status.
module cache_refill_ctrl
  import cache_pkg::*;
#(
  parameter  int LINE_WORDS = LINE_WORDS_DEF,
  parameter  int INDEX_W    = INDEX_W_DEF,
  localparam int OFFSET_W   = $clog2(LINE_WORDS),
  localparam int TAG_W      = 30 - INDEX_W - OFFSET_W
) (
  input  logic                        i_hclk,
  input  logic                        i_hnreset,
  input  logic                        i_miss_req,
  input  logic [29:0]                 i_miss_addr,
  input  logic                        i_flush_req,
  output logic                        o_busy,
  output logic                        o_refill_done,
  output logic                        o_flush_done,
  output logic                        o_crit_valid,
  output logic [31:0]                 o_crit_data,
  output logic                        o_out_sel,
  output logic [29:0]                 o_out_addr,
  input  logic [31:0]                 i_out_rdata,
  input  logic                        i_out_ready,
  output logic                        o_data_we,
  output logic [INDEX_W+OFFSET_W-1:0] o_data_addr,
  output logic [31:0]                 o_data_wdata,
  output logic                        o_tag_we,
  output logic [INDEX_W-1:0]          o_tag_index,
  output logic [TAG_W-1:0]            o_tag_wdata,
  output logic                        o_tag_valid
);

  localparam int CNT_W = OFFSET_W + 1;

  refill_state_t r_state;
  refill_state_t w_state_nxt;

  addr_split_t w_split;
  logic        w_unused;

  logic [TAG_W-1:0]            r_tag;
  logic [INDEX_W-1:0]          r_index;
  logic [INDEX_W-1:0]          r_fidx;
  logic [OFFSET_W-1:0]         r_off;
  logic [CNT_W-1:0]            r_cnt;
  logic                        r_we;
  logic [INDEX_W+OFFSET_W-1:0] r_waddr;
  logic [31:0]                 r_wdata;
  logic                        r_crit_valid;
  logic [31:0]                 r_crit_data;

  logic w_start;
  logic w_capture;
  logic w_last;

  assign w_split = split_addr(i_miss_addr, INDEX_W, OFFSET_W);

  // Upper bits of the zero-extended fields are always zero.
  assign w_unused = ^{w_split.tag[29:TAG_W],
                      w_split.index[29:INDEX_W],
                      w_split.offset[29:OFFSET_W]};

  assign w_start   = (r_state == IDLE) && !i_flush_req && i_miss_req;
  assign w_capture = (r_state == DATA) && i_out_ready;
  assign w_last    = (r_cnt == CNT_W'(LINE_WORDS - 1));

  assign o_busy       = (r_state != IDLE);
  assign o_data_we    = r_we;
  assign o_data_addr  = r_waddr;
  assign o_data_wdata = r_wdata;
  assign o_crit_valid = r_crit_valid;
  assign o_crit_data  = r_crit_data;

  always_ff @(posedge i_hclk or negedge i_hnreset) begin
    if (!i_hnreset) r_state <= IDLE;
    else            r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    o_out_sel     = 1'b0;
    o_out_addr    = '0;
    o_tag_we      = 1'b0;
    o_tag_index   = '0;
    o_tag_wdata   = '0;
    o_tag_valid   = 1'b0;
    o_refill_done = 1'b0;
    o_flush_done  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (i_flush_req)     w_state_nxt = FLUSH;
        else if (i_miss_req) w_state_nxt = ADDR;
      end
      ADDR: begin
        o_out_sel  = 1'b1;
        o_out_addr = {r_tag, r_index, r_off};
        if (i_out_ready) w_state_nxt = DATA;
      end
      DATA: begin
        if (i_out_ready) w_state_nxt = w_last ? TAG : ADDR;
      end
      TAG: begin
        o_tag_we      = 1'b1;
        o_tag_index   = r_index;
        o_tag_wdata   = r_tag;
        o_tag_valid   = 1'b1;
        o_refill_done = 1'b1;
        w_state_nxt   = IDLE;
      end
      FLUSH: begin
        o_tag_we    = 1'b1;
        o_tag_index = r_fidx;
        if (&r_fidx) begin
          o_flush_done = 1'b1;
          w_state_nxt  = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_hclk or negedge i_hnreset) begin
    if (!i_hnreset) begin
      r_tag        <= '0;
      r_index      <= '0;
      r_fidx       <= '0;
      r_off        <= '0;
      r_cnt        <= '0;
      r_we         <= 1'b0;
      r_waddr      <= '0;
      r_wdata      <= '0;
      r_crit_valid <= 1'b0;
      r_crit_data  <= '0;
    end else begin
      r_we         <= 1'b0;
      r_crit_valid <= 1'b0;
      if (w_start) begin
        r_tag   <= w_split.tag[TAG_W-1:0];
        r_index <= w_split.index[INDEX_W-1:0];
        r_off   <= w_split.offset[OFFSET_W-1:0];
        r_cnt   <= '0;
      end
      if ((r_state == IDLE) && i_flush_req) r_fidx <= '0;
      if (r_state == FLUSH) r_fidx <= r_fidx + INDEX_W'(1);
      // Offset wraps naturally at the line boundary.
      if (w_capture) begin
        r_we    <= 1'b1;
        r_waddr <= {r_index, r_off};
        r_wdata <= i_out_rdata;
        r_off   <= r_off + OFFSET_W'(1);
        r_cnt   <= r_cnt + CNT_W'(1);
        if (r_cnt == '0) begin
          r_crit_valid <= 1'b1;
          r_crit_data  <= i_out_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Directed scoreboard bench for cache_refill_ctrl.
// Expected bus/RAM events are queued per test and popped as the DUT emits them.
module tb_cache_refill_ctrl;

  logic        i_hclk;
  logic        i_hnreset;
  logic        i_miss_req;
  logic [29:0] i_miss_addr;
  logic        i_flush_req;
  logic        o_busy;
  logic        o_refill_done;
  logic        o_flush_done;
  logic        o_crit_valid;
  logic [31:0] o_crit_data;
  logic        o_out_sel;
  logic [29:0] o_out_addr;
  logic [31:0] i_out_rdata;
  logic        i_out_ready;
  logic        o_data_we;
  logic [7:0]  o_data_addr;
  logic [31:0] o_data_wdata;
  logic        o_tag_we;
  logic [5:0]  o_tag_index;
  logic [21:0] o_tag_wdata;
  logic        o_tag_valid;

  cache_refill_ctrl dut (
    .i_hclk        (i_hclk),
    .i_hnreset     (i_hnreset),
    .i_miss_req    (i_miss_req),
    .i_miss_addr   (i_miss_addr),
    .i_flush_req   (i_flush_req),
    .o_busy        (o_busy),
    .o_refill_done (o_refill_done),
    .o_flush_done  (o_flush_done),
    .o_crit_valid  (o_crit_valid),
    .o_crit_data   (o_crit_data),
    .o_out_sel     (o_out_sel),
    .o_out_addr    (o_out_addr),
    .i_out_rdata   (i_out_rdata),
    .i_out_ready   (i_out_ready),
    .o_data_we     (o_data_we),
    .o_data_addr   (o_data_addr),
    .o_data_wdata  (o_data_wdata),
    .o_tag_we      (o_tag_we),
    .o_tag_index   (o_tag_index),
    .o_tag_wdata   (o_tag_wdata),
    .o_tag_valid   (o_tag_valid)
  );

  initial i_hclk = 1'b0;
  always #5 i_hclk = ~i_hclk;

  typedef struct {
    int          cyc;
    logic [31:0] a;
    logic [31:0] d;
    bit          f;
  } ev_t;

  ev_t q_oa[$];
  ev_t q_wr[$];
  ev_t q_tag[$];

  int npass  = 0;
  int ntotal = 0;
  int cyc    = 0;

  function automatic logic [31:0] data_of(logic [29:0] a);
    return {2'b10, a} ^ 32'h0F0F_0000;
  endfunction

  // Slave: returns data_of(last accepted address) after wait_n stall
  // cycles on word wait_word of each line.
  int          wait_word = -1;
  int          wait_n    = 0;
  int          slv_wait;
  int          slv_n;
  logic [29:0] slv_addr;

  always @(posedge i_hclk or negedge i_hnreset) begin
    if (!i_hnreset) begin
      slv_wait <= 0;
      slv_n    <= 0;
      slv_addr <= '0;
    end else if (o_out_sel && i_out_ready) begin
      slv_addr <= o_out_addr;
      slv_wait <= ((slv_n % 4) == wait_word) ? wait_n : 0;
      slv_n    <= slv_n + 1;
    end else if (slv_wait != 0) begin
      slv_wait <= slv_wait - 1;
    end
  end

  assign i_out_ready = (slv_wait == 0);
  assign i_out_rdata = data_of(slv_addr);

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Expected refill timeline for a 4-word line starting its IDLE cycle at base.
  task automatic push_refill(int base, logic [29:0] addr, int ww, int wn);
    int          t;
    int          st;
    logic [1:0]  off;
    logic [29:0] wa;
    t   = base + 1;
    off = addr[1:0];
    for (int w = 0; w < 4; w++) begin
      wa = {addr[29:2], off};
      st = (w == ww) ? wn : 0;
      q_oa.push_back('{t, 32'(wa), 32'd0, 1'b0});
      q_wr.push_back('{t + 2 + st, 32'({addr[7:2], off}),
                       data_of(wa), (w == 0)});
      t   = t + 2 + st;
      off = off + 2'd1;
    end
    q_tag.push_back('{t, 32'(addr[7:2]), 32'(addr[29:8]), 1'b1});
  endtask

  task automatic push_flush(int base);
    for (int i = 0; i < 64; i++)
      q_tag.push_back('{base + 1 + i, 32'(i), 32'd0, 1'b0});
  endtask

  task automatic tick();
    ev_t e;
    @(negedge i_hclk);
    cyc++;
    if (o_out_sel && i_out_ready) begin
      if (q_oa.size() == 0) chk("oa_unexpected", 1, 0);
      else begin
        e = q_oa.pop_front();
        chk("oa_cyc", cyc, e.cyc);
        chk("oa_addr", o_out_addr, e.a);
      end
    end
    if (!i_out_ready) chk("sel_in_stall", o_out_sel, 0);
    if (o_data_we) begin
      if (q_wr.size() == 0) chk("wr_unexpected", 1, 0);
      else begin
        e = q_wr.pop_front();
        chk("wr_cyc", cyc, e.cyc);
        chk("wr_addr", o_data_addr, e.a);
        chk("wr_data", o_data_wdata, e.d);
        chk("crit_valid", o_crit_valid, e.f);
        if (e.f) chk("crit_data", o_crit_data, e.d);
      end
    end else if (o_crit_valid) chk("crit_alone", 1, 0);
    if (o_tag_we) begin
      if (q_tag.size() == 0) chk("tag_unexpected", 1, 0);
      else begin
        e = q_tag.pop_front();
        chk("tag_cyc", cyc, e.cyc);
        chk("tag_index", o_tag_index, e.a);
        chk("tag_wdata", o_tag_wdata, e.d);
        chk("tag_valid", o_tag_valid, e.f);
        chk("refill_done", o_refill_done, e.f);
        chk("flush_done", o_flush_done,
            (!e.f && e.a == 32'd63));
        if (!e.f) chk("sel_in_flush", o_out_sel, 0);
      end
    end else if (o_refill_done || o_flush_done) begin
      chk("done_alone", 1, 0);
    end
    if (o_refill_done) i_miss_req = 1'b0;
    if (o_flush_done) i_flush_req = 1'b0;
  endtask

  task automatic run(int max, int exp_end);
    for (int i = 0; i < max; i++) begin
      if (!o_busy && !i_miss_req && !i_flush_req &&
          q_oa.size() == 0 && q_wr.size() == 0 &&
          q_tag.size() == 0) break;
      tick();
    end
    chk("drain", q_oa.size() + q_wr.size() + q_tag.size(), 0);
    chk("end_cyc", cyc, exp_end);
    chk("idle", o_busy, 0);
  endtask

  initial begin
    i_hnreset   = 1'b0;
    i_miss_req  = 1'b0;
    i_flush_req = 1'b0;
    i_miss_addr = '0;
    repeat (2) @(negedge i_hclk);
    chk("rst_busy", o_busy, 0);
    chk("rst_sel", o_out_sel, 0);
    chk("rst_oaddr", o_out_addr, 0);
    chk("rst_dwe", o_data_we, 0);
    chk("rst_twe", o_tag_we, 0);
    chk("rst_crit", o_crit_valid, 0);
    chk("rst_critd", o_crit_data, 0);
    chk("rst_rdone", o_refill_done, 0);
    chk("rst_fdone", o_flush_done, 0);
    i_hnreset = 1'b1;
    @(negedge i_hclk);

    // 1: zero-wait miss, critical offset 3
    i_miss_addr = 30'h123;
    i_miss_req  = 1'b1;
    cyc = 0;
    push_refill(0, 30'h123, -1, 0);
    run(40, 10);
    chk("crit_hold", o_crit_data, data_of(30'h123));

    // 2: two wait states on the second word; address changed after accept
    wait_word   = 1;
    wait_n      = 2;
    i_miss_addr = 30'h1F6;
    i_miss_req  = 1'b1;
    cyc = 0;
    push_refill(0, 30'h1F6, 1, 2);
    tick();
    i_miss_addr = 30'h3FFF_FFFF;
    run(40, 12);
    wait_word = -1;
    wait_n    = 0;

    // 3: whole-cache flush
    i_flush_req = 1'b1;
    cyc = 0;
    push_flush(0);
    run(100, 65);

    // 4: flush wins over a simultaneous miss, miss follows
    i_miss_addr = 30'h2A5;
    i_miss_req  = 1'b1;
    i_flush_req = 1'b1;
    cyc = 0;
    push_flush(0);
    push_refill(65, 30'h2A5, -1, 0);
    run(120, 75);

    // 5: reset during DATA of the second word
    i_miss_addr = 30'h123;
    i_miss_req  = 1'b1;
    cyc = 0;
    push_refill(0, 30'h123, -1, 0);
    repeat (4) tick();
    chk("pre_rst_oa", q_oa.size(), 2);
    chk("pre_rst_wr", q_wr.size(), 3);
    q_oa.delete();
    q_wr.delete();
    q_tag.delete();
    i_hnreset  = 1'b0;
    i_miss_req = 1'b0;
    #1;
    chk("ar_busy", o_busy, 0);
    chk("ar_sel", o_out_sel, 0);
    chk("ar_oaddr", o_out_addr, 0);
    chk("ar_dwe", o_data_we, 0);
    chk("ar_daddr", o_data_addr, 0);
    chk("ar_dwdata", o_data_wdata, 0);
    chk("ar_twe", o_tag_we, 0);
    chk("ar_crit", o_crit_valid, 0);
    chk("ar_critd", o_crit_data, 0);
    repeat (2) @(negedge i_hclk);
    i_hnreset = 1'b1;
    repeat (20) tick();
    chk("post_rst_idle", o_busy, 0);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
